// File: rtl/teclado_acumulador.sv
// Keypad digit accumulator: builds a BCD entry from key strobes and
// hands the committed number downstream over a valid/ready handshake.
module teclado_acumulador #(
  parameter int N_DIGITS    = 4,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    key_code,
  input  logic                          key_valid,
  output logic [4*N_DIGITS-1:0]         disp_value,
  output logic [$clog2(N_DIGITS+1)-1:0] digit_count,
  output logic [4*N_DIGITS-1:0]         out_value,
  output logic [$clog2(N_DIGITS+1)-1:0] out_count,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overflow,
  output logic                          timeout
);

  localparam int W  = 4 * N_DIGITS;
  localparam int CW = $clog2(N_DIGITS + 1);
  localparam int TW = (TIMEOUT_CYC < 1) ? 1
                    : $clog2(TIMEOUT_CYC + 1);

  localparam logic [CW-1:0] CNT_FULL = CW'(N_DIGITS);
  localparam logic [TW-1:0] IDLE_MAX =
    TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic {
    ENTRY,
    PRESENT
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  oval_q, oval_d;
  logic [CW-1:0] ocnt_q, ocnt_d;
  logic          ovld_q, ovld_d;
  logic          ovf_q, ovf_d;
  logic          tmo_q, tmo_d;
  logic [TW-1:0] idle_q, idle_d;

  logic is_dig;
  logic is_clr;
  logic is_ent;
  logic is_bsp;

  assign is_dig = key_code <= 4'd9;
  assign is_clr = key_code == 4'hA;
  assign is_ent = key_code == 4'hB;
  assign is_bsp = key_code == 4'hC;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    oval_d  = oval_q;
    ocnt_d  = ocnt_q;
    ovld_d  = ovld_q;
    ovf_d   = 1'b0;
    tmo_d   = 1'b0;
    idle_d  = '0;

    if (state_q == PRESENT && out_ready) begin
      ovld_d  = 1'b0;
      state_d = ENTRY;
    end

    if (key_valid) begin
      unique case (1'b1)
        is_dig: begin
          if (cnt_q < CNT_FULL) begin
            buf_d = (buf_q << 4) | W'(key_code);
            cnt_d = cnt_q + CW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        is_clr: begin
          buf_d = '0;
          cnt_d = '0;
        end
        is_bsp: begin
          if (cnt_q != '0) begin
            buf_d = buf_q >> 4;
            cnt_d = cnt_q - CW'(1);
          end
        end
        is_ent: begin
          // Enter while a value is still waiting downstream is dropped.
          if (state_q == ENTRY && cnt_q != '0) begin
            oval_d  = buf_q;
            ocnt_d  = cnt_q;
            ovld_d  = 1'b1;
            buf_d   = '0;
            cnt_d   = '0;
            state_d = PRESENT;
          end
        end
        default: ;
      endcase
    end else if (TIMEOUT_CYC != 0 && state_q == ENTRY
                 && cnt_q != '0) begin
      if (idle_q == IDLE_MAX) begin
        buf_d = '0;
        cnt_d = '0;
        tmo_d = 1'b1;
      end else begin
        idle_d = idle_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ENTRY;
      buf_q   <= '0;
      cnt_q   <= '0;
      oval_q  <= '0;
      ocnt_q  <= '0;
      ovld_q  <= 1'b0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      oval_q  <= oval_d;
      ocnt_q  <= ocnt_d;
      ovld_q  <= ovld_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      idle_q  <= idle_d;
    end
  end

  assign disp_value  = buf_q;
  assign digit_count = cnt_q;
  assign out_value   = oval_q;
  assign out_count   = ocnt_q;
  assign out_valid   = ovld_q;
  assign overflow    = ovf_q;
  assign timeout     = tmo_q;

endmodule
